xor_parity_acc: RTL and testbench
=================================

Name: xor_parity_acc

Overview:
Streaming, parametrised successor to the two-input XOR exercise. It accumulates the bitwise XOR of a frame of WIDTH-bit words received over a valid/ready input and emits one result per frame. Each result carries the column-parity word, a single parity bit (even or odd mode), the word count and a truncation flag. It sits between a word source and a checker/consumer as a frame integrity generator.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- MAX_WORDS, 16, maximum words per frame; the frame is force-closed when this is reached (>=1).
- ODD_PARITY, 0, 0 = even parity bit, 1 = odd parity bit.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  input word.
- in_last  input  1  marks the final word of the frame.
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  XOR of all words in the frame.
- out_par  output  1  reduction-XOR of out_data, XORed with ODD_PARITY.
- out_count  output  CW  words in the frame; CW = $clog2(MAX_WORDS+1).
- out_trunc  output  1  frame closed by MAX_WORDS without in_last.

Behaviour:
- Reset (rst_n low, asynchronous): state=ACC, acc=0, cnt=0, out_valid=0, out_data=0, out_par=0, out_count=0, out_trunc=0. Inputs are ignored while rst_n is low.
- States: ACC (collecting words) and HOLD (presenting a result).
- in_ready = (state==ACC), combinational from state only. No combinational path from out_ready to in_ready.
- ACC, on in_valid & in_ready:
  - acc <= acc ^ in_data; cnt <= cnt+1.
  - If in_last=1 or cnt==MAX_WORDS-1: go to HOLD with out_data <= acc ^ in_data, out_count <= cnt+1, out_par <= (^(acc^in_data)) ^ ODD_PARITY, out_trunc <= (in_last==0), out_valid <= 1.
  - If in_last and the limit coincide, out_trunc=0.
- ACC with in_valid=0: no change.
- HOLD: outputs stay stable while out_valid=1 & out_ready=0; no input is accepted.
- HOLD, on out_ready=1: out_valid <= 0, acc <= 0, cnt <= 0, next state ACC. The out_* data fields keep their last values.
- Latency: the result is valid the cycle after the closing word is accepted. There is a 1-cycle minimum bubble on the input after each result handshake. Throughput is MAX_WORDS words per MAX_WORDS+1 cycles at best (when out_ready is held high).
- Empty frames are impossible: a result always has out_count >= 1.
- MAX_WORDS=1: every accepted word closes its own frame, with out_trunc = ~in_last.
- Asynchronous reset mid-frame or mid-HOLD discards partial or pending results and returns to the reset values.
- Width rules: out_count is zero-extended to CW bits; the cnt compare uses CW bits; WIDTH=1 degenerates to serial 1-bit parity.

Decomposition:
- Package xor_pkg holds:
  - the state encoding constants ST_ACC=1'b0 and ST_HOLD=1'b1;
  - the parity mode constants PAR_EVEN=0 and PAR_ODD=1;
  - a count-width helper function.
- No sub-module is needed. The reduction XOR is a single expression. A one-module FSM+datapath of about 150 lines is expected.

Test Plan:
- WIDTH=8, even mode. Send single word 0xA5 with in_last=1 -> next cycle out_valid=1, out_data=0xA5, out_count=1, out_par=0, out_trunc=0.
- Send 0x0F, 0xF0, 0xFF (last on the third word) -> out_data=0x00, out_count=3, out_par=0. The full 2-bit XOR truth table (00/01/10/11) runs at WIDTH=1 as frames {0,0}, {0,1}, {1,0}, {1,1} -> out_data 0, 1, 1, 0.
- MAX_WORDS=4. Send 5 words 0x01, 0x02, 0x04, 0x08, 0x10 with no in_last -> first result out_data=0x0F, out_count=4, out_trunc=1. The fifth word (with last) forms the next frame: out_data=0x10, out_count=1.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> in_ready=0 and all out_* stable. Raise out_ready -> out_valid=0 next cycle and in_ready=1.
- ODD_PARITY=1: frame {0x01} -> out_par=0; frame {0x03} -> out_par=1.
- Assert rst_n=0 after 2 words of a frame, then release and send {0x3C, last} -> out_data=0x3C, out_count=1. There must be no carry-over from the aborted frame.

Source files
------------

// File: rtl/xor_pkg.sv
// xor_pkg: shared state encoding, parity modes and count-width helper for xor_parity_acc
package xor_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

    function automatic int cnt_w(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/xor_parity_acc.sv
// xor_parity_acc: per-frame XOR accumulator emitting column parity, parity bit, word count and truncation flag
module xor_parity_acc
    import xor_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MAX_WORDS  = 16,
    parameter bit ODD_PARITY = PAR_EVEN,
    localparam int CW        = cnt_w(MAX_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_par,
    output logic [CW-1:0]    out_count,
    output logic             out_trunc
);

    localparam logic [CW-1:0] LIMIT = CW'(MAX_WORDS - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_par;
    logic [CW-1:0]    r_out_count;
    logic             r_out_trunc;

    logic [WIDTH-1:0] w_acc_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_close;

    assign in_ready  = (r_state == ST_ACC);
    assign w_acc_nxt = r_acc ^ in_data;
    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_close   = in_last | (r_cnt == LIMIT);

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_par   = r_out_par;
    assign out_count = r_out_count;
    assign out_trunc = r_out_trunc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ACC;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_par   <= 1'b0;
            r_out_count <= '0;
            r_out_trunc <= 1'b0;
        end else if (r_state == ST_ACC) begin
            if (in_valid) begin
                r_acc <= w_acc_nxt;
                r_cnt <= w_cnt_nxt;
                if (w_close) begin
                    r_state     <= ST_HOLD;
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_acc_nxt;
                    r_out_par   <= (^w_acc_nxt) ^ ODD_PARITY;
                    r_out_count <= w_cnt_nxt;
                    r_out_trunc <= ~in_last;
                end
            end
        end else if (out_ready) begin
            // result fields are left in place; only the handshake and the accumulator clear
            r_state     <= ST_ACC;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end
    end

endmodule

// File: tb/tb_xor_parity_acc.sv
// tb_xor_parity_acc: directed checks on three configurations (8b/16 even, 1b/16 even, 8b/4 odd)
module tb_xor_parity_acc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    logic       a_in_valid = 0, a_in_last = 0, a_out_ready = 0;
    logic [7:0] a_in_data = '0;
    logic       a_in_ready, a_out_valid, a_out_par, a_out_trunc;
    logic [7:0] a_out_data;
    logic [4:0] a_out_count;

    logic       b_in_valid = 0, b_in_last = 0, b_out_ready = 0;
    logic [0:0] b_in_data = '0;
    logic       b_in_ready, b_out_valid, b_out_par, b_out_trunc;
    logic [0:0] b_out_data;
    logic [4:0] b_out_count;

    logic       c_in_valid = 0, c_in_last = 0, c_out_ready = 0;
    logic [7:0] c_in_data = '0;
    logic       c_in_ready, c_out_valid, c_out_par, c_out_trunc;
    logic [7:0] c_out_data;
    logic [2:0] c_out_count;

    xor_parity_acc #(.WIDTH(8), .MAX_WORDS(16), .ODD_PARITY(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_last(a_in_last), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_par(a_out_par),
        .out_count(a_out_count), .out_trunc(a_out_trunc));

    xor_parity_acc #(.WIDTH(1), .MAX_WORDS(16), .ODD_PARITY(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_par(b_out_par),
        .out_count(b_out_count), .out_trunc(b_out_trunc));

    xor_parity_acc #(.WIDTH(8), .MAX_WORDS(4), .ODD_PARITY(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_last(c_in_last), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .out_par(c_out_par),
        .out_count(c_out_count), .out_trunc(c_out_trunc));

    // every task enters and leaves on a falling edge
    task automatic a_push(input logic [7:0] d, input logic l);
        a_in_valid = 1'b1; a_in_data = d; a_in_last = l;
        @(negedge clk);
        a_in_valid = 1'b0; a_in_last = 1'b0;
    endtask

    task automatic b_push(input logic d, input logic l);
        b_in_valid = 1'b1; b_in_data = d; b_in_last = l;
        @(negedge clk);
        b_in_valid = 1'b0; b_in_last = 1'b0;
    endtask

    task automatic c_push(input logic [7:0] d, input logic l);
        c_in_valid = 1'b1; c_in_data = d; c_in_last = l;
        @(negedge clk);
        c_in_valid = 1'b0; c_in_last = 1'b0;
    endtask

    task automatic a_pop();
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL a_pop_valid got=%b exp=0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL a_pop_ready got=%b exp=1", a_in_ready); end
    endtask

    task automatic c_pop();
        c_out_ready = 1'b1;
        @(negedge clk);
        c_out_ready = 1'b0;
        checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL c_pop_valid got=%b exp=0", c_out_valid); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", a_in_ready); end
        checks++; if (a_out_data !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", a_out_data); end
        checks++; if (a_out_count !== 5'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", a_out_count); end
        checks++; if ({a_out_par, a_out_trunc} !== 2'b00) begin errors++; $display("FAIL rst_par_trunc got=%b exp=00", {a_out_par, a_out_trunc}); end
        checks++; if (c_out_count !== 3'd0) begin errors++; $display("FAIL rst_c_count got=%0d exp=0", c_out_count); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        a_push(8'hA5, 1'b1);
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", a_out_valid); end
        checks++; if (a_out_data !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", a_out_data); end
        checks++; if (a_out_count !== 5'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", a_out_count); end
        checks++; if ({a_out_par, a_out_trunc} !== 2'b00) begin errors++; $display("FAIL single_par_trunc got=%b exp=00", {a_out_par, a_out_trunc}); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL single_in_ready got=%b exp=0", a_in_ready); end
        a_pop();
    endtask

    task automatic test_multi();
        a_push(8'h0F, 1'b0);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL multi_early_valid got=%b exp=0", a_out_valid); end
        a_push(8'hF0, 1'b0);
        a_push(8'hFF, 1'b1);
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL multi_valid got=%b exp=1", a_out_valid); end
        checks++; if (a_out_data !== 8'h00) begin errors++; $display("FAIL multi_data got=%h exp=00", a_out_data); end
        checks++; if (a_out_count !== 5'd3) begin errors++; $display("FAIL multi_count got=%0d exp=3", a_out_count); end
        checks++; if ({a_out_par, a_out_trunc} !== 2'b00) begin errors++; $display("FAIL multi_par_trunc got=%b exp=00", {a_out_par, a_out_trunc}); end
        a_pop();
    endtask

    task automatic test_width1();
        logic [1:0] pat;
        for (int i = 0; i < 4; i++) begin
            pat = 2'(i);
            b_push(pat[1], 1'b0);
            b_push(pat[0], 1'b1);
            checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL w1_valid_%0d got=%b exp=1", i, b_out_valid); end
            checks++; if (b_out_data !== (pat[1] ^ pat[0])) begin errors++; $display("FAIL w1_data_%0d got=%b exp=%b", i, b_out_data, pat[1] ^ pat[0]); end
            checks++; if (b_out_par !== (pat[1] ^ pat[0])) begin errors++; $display("FAIL w1_par_%0d got=%b exp=%b", i, b_out_par, pat[1] ^ pat[0]); end
            checks++; if (b_out_count !== 5'd2) begin errors++; $display("FAIL w1_count_%0d got=%0d exp=2", i, b_out_count); end
            b_out_ready = 1'b1;
            @(negedge clk);
            b_out_ready = 1'b0;
        end
    endtask

    task automatic test_trunc();
        c_push(8'h01, 1'b0);
        c_push(8'h02, 1'b0);
        c_push(8'h04, 1'b0);
        checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL trunc_early_valid got=%b exp=0", c_out_valid); end
        c_push(8'h08, 1'b0);
        checks++; if (c_out_valid !== 1'b1) begin errors++; $display("FAIL trunc_valid got=%b exp=1", c_out_valid); end
        checks++; if (c_out_data !== 8'h0F) begin errors++; $display("FAIL trunc_data got=%h exp=0f", c_out_data); end
        checks++; if (c_out_count !== 3'd4) begin errors++; $display("FAIL trunc_count got=%0d exp=4", c_out_count); end
        checks++; if (c_out_trunc !== 1'b1) begin errors++; $display("FAIL trunc_flag got=%b exp=1", c_out_trunc); end
        checks++; if (c_out_par !== 1'b1) begin errors++; $display("FAIL trunc_par got=%b exp=1", c_out_par); end
        c_pop();
        c_push(8'h10, 1'b1);
        checks++; if (c_out_data !== 8'h10) begin errors++; $display("FAIL trunc_next_data got=%h exp=10", c_out_data); end
        checks++; if (c_out_count !== 3'd1) begin errors++; $display("FAIL trunc_next_count got=%0d exp=1", c_out_count); end
        checks++; if (c_out_trunc !== 1'b0) begin errors++; $display("FAIL trunc_next_flag got=%b exp=0", c_out_trunc); end
        c_pop();
    endtask

    task automatic test_limit_last();
        c_push(8'h01, 1'b0);
        c_push(8'h02, 1'b0);
        c_push(8'h04, 1'b0);
        c_push(8'h08, 1'b1);
        checks++; if (c_out_count !== 3'd4) begin errors++; $display("FAIL coinc_count got=%0d exp=4", c_out_count); end
        checks++; if (c_out_trunc !== 1'b0) begin errors++; $display("FAIL coinc_trunc got=%b exp=0", c_out_trunc); end
        c_pop();
    endtask

    task automatic test_odd();
        c_push(8'h01, 1'b1);
        checks++; if (c_out_par !== 1'b0) begin errors++; $display("FAIL odd_par_01 got=%b exp=0", c_out_par); end
        c_pop();
        c_push(8'h03, 1'b1);
        checks++; if (c_out_par !== 1'b1) begin errors++; $display("FAIL odd_par_03 got=%b exp=1", c_out_par); end
        checks++; if (c_out_data !== 8'h03) begin errors++; $display("FAIL odd_data_03 got=%h exp=03", c_out_data); end
        c_pop();
    endtask

    task automatic test_backpressure();
        a_push(8'h11, 1'b1);
        a_in_valid = 1'b1; a_in_data = 8'hFF; a_in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d got=%b exp=0", i, a_in_ready); end
            checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_%0d got=%b exp=1", i, a_out_valid); end
            checks++; if ({a_out_data, a_out_count, a_out_par, a_out_trunc} !== {8'h11, 5'd1, 1'b0, 1'b0})
                begin errors++; $display("FAIL bp_stable_%0d got=%h/%0d/%b/%b exp=11/1/0/0", i, a_out_data, a_out_count, a_out_par, a_out_trunc); end
        end
        a_in_valid = 1'b0; a_in_last = 1'b0;
        a_pop();
        checks++; if (a_out_data !== 8'h11) begin errors++; $display("FAIL bp_keep_data got=%h exp=11", a_out_data); end
        a_push(8'h22, 1'b1);
        checks++; if (a_out_data !== 8'h22) begin errors++; $display("FAIL bp_next_data got=%h exp=22", a_out_data); end
        checks++; if (a_out_count !== 5'd1) begin errors++; $display("FAIL bp_next_count got=%0d exp=1", a_out_count); end
        a_pop();
    endtask

    task automatic test_reset_mid();
        a_push(8'h55, 1'b0);
        a_push(8'h66, 1'b0);
        c_push(8'h01, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL arst_c_valid got=%b exp=0", c_out_valid); end
        checks++; if (c_out_count !== 3'd0) begin errors++; $display("FAIL arst_c_count got=%0d exp=0", c_out_count); end
        checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL arst_c_in_ready got=%b exp=1", c_in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a_push(8'h3C, 1'b1);
        checks++; if (a_out_data !== 8'h3C) begin errors++; $display("FAIL arst_data got=%h exp=3c", a_out_data); end
        checks++; if (a_out_count !== 5'd1) begin errors++; $display("FAIL arst_count got=%0d exp=1", a_out_count); end
        checks++; if (a_out_par !== 1'b0) begin errors++; $display("FAIL arst_par got=%b exp=0", a_out_par); end
        a_pop();
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_width1();
        test_trunc();
        test_limit_last();
        test_odd();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
